// File: rtl/uart_pkg.sv
// Shared types for the UART transmit queue.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } txq_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; pointers wrap naturally since DEPTH is a power of two.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter with a start/done handshake.
// Define UART_TXQ_STATS_EN to add the tx_count completion counter.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [UART_DATA_W-1:0] tx_data_in,
  output logic                   start,
  input  logic                   tx_active,
  input  logic                   done_tx,
  output logic [LW-1:0]          level,
  output logic                   empty,
  output logic                   busy
`ifdef UART_TXQ_STATS_EN
  ,
  output logic [15:0]            tx_count
`endif
);

  txq_state_e             state;
  txq_state_e             state_nx;
  logic                   full;
  logic [UART_DATA_W-1:0] head;
  logic                   push;
  logic                   pop;
  logic                   bypass;

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !bypass;
  assign start    = (state == START);
  assign busy     = (state != IDLE);

  uart_sync_fifo #(
    .W     (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // An empty idle queue hands the byte straight to the transmitter,
  // so start follows the accepting edge by one clock.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    bypass   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tx_active) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = START;
          end else if (in_valid) begin
            bypass   = 1'b1;
            state_nx = START;
          end
        end
      end
      START:     state_nx = WAIT_DONE;
      WAIT_DONE: if (done_tx) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data_in <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        tx_data_in <= head;
      end else if (bypass) begin
        tx_data_in <= in_data;
      end
    end
  end

`ifdef UART_TXQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_count <= '0;
    end else if (state == WAIT_DONE && done_tx) begin
      tx_count <= tx_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue against a queue-based transfer model.
module tb_uart_tx_queue;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    tx_data_in;
  logic          start;
  logic          tx_active = 1'b0;
  logic          done_tx = 1'b0;
  logic [LW-1:0] level;
  logic          empty;
  logic          busy;
`ifdef UART_TXQ_STATS_EN
  logic [15:0]   tx_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: bytes waiting to launch, launch/wait flags, completion count.
  logic [7:0] m_q[$];
  int         m_level   = 0;
  bit         m_started = 0;
  bit         m_wait    = 0;
  int         m_count   = 0;

  always #5 clk = ~clk;

  uart_tx_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_data_in (tx_data_in),
    .start      (start),
    .tx_active  (tx_active),
    .done_tx    (done_tx),
    .level      (level),
    .empty      (empty),
    .busy       (busy)
`ifdef UART_TXQ_STATS_EN
    ,
    .tx_count   (tx_count)
`endif
  );

  // One clock; samples at the following falling edge and advances the model.
  task automatic step(output bit acc, output bit gs, output logic [7:0] eb);
    bit dn;
    acc = !rst && in_valid && (m_level < DEPTH);
    dn  = !rst && done_tx && m_wait;
    @(posedge clk);
    @(negedge clk);
    gs = 1'b0;
    eb = 8'hxx;
    if (rst) begin
      m_q.delete();
      m_level   = 0;
      m_started = 0;
      m_wait    = 0;
      m_count   = 0;
    end else begin
      if (acc) begin
        m_q.push_back(in_data);
        m_level++;
      end
      if (dn) begin
        m_wait  = 0;
        m_count = (m_count + 1) % 65536;
      end
      if (m_started) begin
        m_wait    = 1;
        m_started = 0;
      end
      if (start) begin
        gs = 1'b1;
        m_started = 1;
        if (m_q.size() > 0) begin
          eb = m_q.pop_front();
          m_level--;
        end
      end
    end
  endtask

  task automatic do_reset();
    bit a, g;
    logic [7:0] e;
    in_valid  = 1'b0;
    done_tx   = 1'b0;
    rst       = 1'b1;
    step(a, g, e);
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (level !== '0 || empty !== 1'b1 || in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_fifo level=%0d empty=%b in_ready=%b want 0/1/1", level, empty, in_ready); end
    checks++;
    if (busy !== 1'b0 || start !== 1'b0 || tx_data_in !== 8'h00)
      begin failures++; $display("FAIL reset_fsm busy=%b start=%b data=%h want 0/0/00", busy, start, tx_data_in); end
  endtask

  task automatic test_single();
    bit a, g;
    logic [7:0] e;
    do_reset();
    tx_active = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    step(a, g, e);
    in_valid  = 1'b0;
    checks++;
    if (start !== 1'b1 || tx_data_in !== 8'hA5 || busy !== 1'b1)
      begin failures++; $display("FAIL single_launch start=%b data=%h busy=%b want 1/a5/1", start, tx_data_in, busy); end
    checks++;
    if (level !== '0)
      begin failures++; $display("FAIL single_level got %0d want 0", level); end
    tx_active = 1'b1;
    step(a, g, e);
    checks++;
    if (start !== 1'b0 || tx_data_in !== 8'hA5)
      begin failures++; $display("FAIL single_pulse start=%b data=%h want 0/a5", start, tx_data_in); end
    step(a, g, e);
    done_tx = 1'b1;
    step(a, g, e);
    done_tx   = 1'b0;
    tx_active = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_data_in !== 8'hA5)
      begin failures++; $display("FAIL single_done busy=%b data=%h want 0/a5", busy, tx_data_in); end
  endtask

  task automatic test_fill();
    bit a, g, seen;
    logic [7:0] e;
    do_reset();
    seen      = 0;
    tx_active = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      checks++;
      if (in_ready !== (i < DEPTH))
        begin failures++; $display("FAIL fill_ready i=%0d got %b want %b", i, in_ready, i < DEPTH); end
      step(a, g, e);
      seen |= start;
    end
    in_valid = 1'b0;
    checks++;
    if (level !== LW'(DEPTH) || in_ready !== 1'b0 || empty !== 1'b0)
      begin failures++; $display("FAIL fill_full level=%0d ready=%b empty=%b want %0d/0/0", level, in_ready, empty, DEPTH); end
    checks++;
    if (seen)
      begin failures++; $display("FAIL fill_no_start got start want none"); end
    // Pop and refused push on the same edge while full.
    tx_active = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    step(a, g, e);
    in_valid  = 1'b0;
    tx_active = 1'b1;
    checks++;
    if (level !== LW'(DEPTH - 1) || start !== 1'b1 || tx_data_in !== 8'h01 || a)
      begin failures++; $display("FAIL full_pop_push level=%0d start=%b data=%h want %0d/1/01", level, start, tx_data_in, DEPTH - 1); end
  endtask

  task automatic test_order_wrap();
    bit a, g;
    logic [7:0] e;
    int idx, nl, cnt;
    do_reset();
    idx = 0; nl = 0; cnt = 0;
    tx_active = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (nl == 12 && !m_started && !m_wait && m_q.size() == 0) break;
      in_valid = (idx < 12) && ($urandom_range(0, 2) != 0);
      in_data  = 8'(8'h10 + idx);
      if (cnt > 0) begin
        cnt--;
        done_tx = (cnt == 0);
      end else begin
        done_tx   = 1'b0;
        tx_active = 1'b0;
      end
      step(a, g, e);
      if (a) idx++;
      if (g) begin
        checks++;
        if (tx_data_in !== e || tx_data_in !== 8'(8'h10 + nl))
          begin failures++; $display("FAIL order_byte n=%0d got %h want %h", nl, tx_data_in, 8'(8'h10 + nl)); end
        nl++;
        tx_active = 1'b1;
        cnt = $urandom_range(2, 5);
      end
      checks++;
      if (level !== LW'(m_level) || empty !== (m_level == 0) || busy !== (m_started || m_wait))
        begin failures++; $display("FAIL order_state level=%0d empty=%b busy=%b want %0d/%b/%b", level, empty, busy, m_level, m_level == 0, m_started || m_wait); end
    end
    in_valid = 1'b0;
    done_tx  = 1'b0;
    checks++;
    if (nl != 12 || idx != 12)
      begin failures++; $display("FAIL order_count launched=%0d pushed=%0d want 12/12", nl, idx); end
  endtask

  task automatic test_simul();
    bit a, g;
    logic [7:0] e;
    do_reset();
    tx_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h31 + i);
      step(a, g, e);
    end
    checks++;
    if (level !== LW'(3))
      begin failures++; $display("FAIL simul_pre level=%0d want 3", level); end
    tx_active = 1'b0;
    in_data   = 8'h34;
    step(a, g, e);
    in_valid  = 1'b0;
    tx_active = 1'b1;
    checks++;
    if (level !== LW'(3) || start !== 1'b1 || tx_data_in !== 8'h31)
      begin failures++; $display("FAIL simul_level level=%0d start=%b data=%h want 3/1/31", level, start, tx_data_in); end
  endtask

  task automatic test_reset_mid();
    bit a, g, seen;
    logic [7:0] e;
    do_reset();
    tx_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      step(a, g, e);
    end
    in_valid  = 1'b0;
    tx_active = 1'b0;
    step(a, g, e);
    tx_active = 1'b1;
    step(a, g, e);
    checks++;
    if (busy !== 1'b1 || start !== 1'b0 || level !== LW'(4))
      begin failures++; $display("FAIL mid_pre busy=%b start=%b level=%0d want 1/0/4", busy, start, level); end
    rst = 1'b1;
    step(a, g, e);
    rst = 1'b0;
    checks++;
    if (level !== '0 || empty !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0 || tx_data_in !== 8'h00)
      begin failures++; $display("FAIL mid_reset level=%0d empty=%b ready=%b busy=%b start=%b data=%h want 0/1/1/0/0/00", level, empty, in_ready, busy, start, tx_data_in); end
    in_valid = 1'b1;
    in_data  = 8'h77;
    step(a, g, e);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(a, g, e);
      seen |= start;
    end
    checks++;
    if (seen || level !== LW'(1))
      begin failures++; $display("FAIL mid_hold start_seen=%b level=%0d want 0/1", seen, level); end
    tx_active = 1'b0;
    step(a, g, e);
    checks++;
    if (start !== 1'b1 || tx_data_in !== 8'h77)
      begin failures++; $display("FAIL mid_release start=%b data=%h want 1/77", start, tx_data_in); end
  endtask

`ifdef UART_TXQ_STATS_EN
  task automatic test_stats();
    bit a, g;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tx_active = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'($urandom_range(0, 255));
      step(a, g, e);
      in_valid  = 1'b0;
      tx_active = 1'b1;
      step(a, g, e);
      done_tx = 1'b1;
      step(a, g, e);
      done_tx   = 1'b0;
      tx_active = 1'b0;
      step(a, g, e);
    end
    checks++;
    if (tx_count !== 16'd3 || m_count != 3)
      begin failures++; $display("FAIL stats_count got %0d want 3", tx_count); end
    done_tx = 1'b1;
    step(a, g, e);
    done_tx = 1'b0;
    checks++;
    if (tx_count !== 16'(m_count) || tx_count !== 16'd3)
      begin failures++; $display("FAIL stats_spurious got %0d want 3", tx_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_order_wrap();
    test_simul();
    test_reset_mid();
`ifdef UART_TXQ_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
